// File: rtl/fp_pkg.sv
// Shared FP32 constants, FSM state encoding and the packed single-precision layout
// for the adder normalise/round stage.
package fp_pkg;

   localparam int unsigned FP_EXP_W  = 8;
   localparam int unsigned FP_FRAC_W = 23;

   localparam int unsigned EXP_MAX = (1 << FP_EXP_W) - 1;
   localparam int unsigned BIAS    = (1 << (FP_EXP_W - 1)) - 1;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      NORM  = 3'd2,
      ROUND = 3'd3,
      DONE  = 3'd4
   } norm_state_t;

   typedef struct packed {
      logic                 sign;
      logic [FP_EXP_W-1:0]  exp;
      logic [FP_FRAC_W-1:0] frac;
   } fp32_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even with renormalise and overflow-to-Inf.
// Flag outputs exist only when FP_NORM_FLAGS_EN is defined.
module fp_round_rne #(
   parameter int unsigned EXP_W  = 8,
   parameter int unsigned FRAC_W = 23
) (
   input  logic [FRAC_W+3:0] i_mant,
   input  logic [EXP_W:0]    i_exp,
   output logic [EXP_W-1:0]  o_exp_c,
   output logic [FRAC_W-1:0] o_frac_c
`ifdef FP_NORM_FLAGS_EN
   ,
   output logic              o_ovf_c,
   output logic              o_unf_c,
   output logic              o_inexact_c
`endif
);

   localparam int unsigned    SW      = FRAC_W + 2;
   localparam int unsigned    XW      = EXP_W + 1;
   localparam logic [XW-1:0]  EXP_TOP = XW'((1 << EXP_W) - 1);

   logic          w_inc;
   logic [SW-1:0] w_sum;
   logic [XW-1:0] w_exp_rnd;
   logic          w_ovf;

   assign w_inc = i_mant[2] & (i_mant[1] | i_mant[0] | i_mant[3]);
   assign w_sum = {1'b0, i_mant[FRAC_W+3:3]} + SW'(w_inc);

   // Carry out bumps the exponent; a subnormal reaching the hidden bit gets field 1.
   assign w_exp_rnd = w_sum[SW-1] ? (i_exp + XW'(1)) :
                      w_sum[SW-2] ? i_exp : '0;

   assign w_ovf    = (w_exp_rnd >= EXP_TOP);
   assign o_exp_c  = w_ovf ? '1 : w_exp_rnd[EXP_W-1:0];
   assign o_frac_c = w_ovf ? '0 : w_sum[FRAC_W-1:0];

`ifdef FP_NORM_FLAGS_EN
   assign o_ovf_c     = w_ovf;
   assign o_inexact_c = |i_mant[2:0];
   assign o_unf_c     = ~w_ovf & (w_exp_rnd == '0) & (|i_mant[2:0]);
`endif

endmodule

// File: rtl/fp_norm_round.sv
// Post-add normalise/round stage: one-bit-per-clock left normalise, then RNE.
// Define FP_NORM_FLAGS_EN to add out_flags = {overflow, underflow, inexact}.
module fp_norm_round
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W  = FP_EXP_W,
   parameter int unsigned FRAC_W = FP_FRAC_W
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_sign,
   input  logic [EXP_W-1:0]          in_exp,
   input  logic [FRAC_W+4:0]         in_mant,
   input  logic                      in_special,
   input  logic [EXP_W+FRAC_W:0]     in_special_val,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [EXP_W+FRAC_W:0]     out_data
`ifdef FP_NORM_FLAGS_EN
   ,
   output logic [2:0]                out_flags
`endif
);

   localparam int unsigned   MW      = FRAC_W + 5;
   localparam int unsigned   DW      = 1 + EXP_W + FRAC_W;
   localparam int unsigned   XW      = EXP_W + 1;
   localparam logic [XW-1:0] EXP_ONE = XW'(1);
   localparam logic [XW-1:0] EXP_TOP = XW'((1 << EXP_W) - 1);

   norm_state_t   r_state, w_nxt_state;
   logic          r_sign, w_nxt_sign;
   logic [XW-1:0] r_exp, w_nxt_exp;
   logic [MW-1:0] r_mant, w_nxt_mant;
   logic [DW-1:0] r_out_data, w_nxt_data;
   logic          r_out_valid;
   logic          r_in_ready;

   logic [MW-1:0]     w_shr_mant;
   logic [MW-1:0]     w_shl_mant;
   logic [XW-1:0]     w_exp_inc;
   logic [XW-1:0]     w_exp_dec;
   logic [XW-1:0]     w_in_exp;
   logic [DW-1:0]     w_inf;
   logic [DW-1:0]     w_zero;
   logic [EXP_W-1:0]  w_rnd_exp;
   logic [FRAC_W-1:0] w_rnd_frac;

`ifdef FP_NORM_FLAGS_EN
   logic [2:0] r_flags, w_nxt_flags;
   logic       w_rnd_ovf, w_rnd_unf, w_rnd_inx;
`endif

   // Right shift on carry folds the dropped bit into sticky.
   assign w_shr_mant = {1'b0, r_mant[MW-1:2], r_mant[1] | r_mant[0]};
   assign w_shl_mant = {r_mant[MW-2:0], 1'b0};
   assign w_exp_inc  = r_exp + XW'(1);
   assign w_exp_dec  = r_exp - XW'(1);
   assign w_in_exp   = (in_exp == '0) ? EXP_ONE : {1'b0, in_exp};
   assign w_inf      = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
   assign w_zero     = {r_sign, {(DW-1){1'b0}}};

   fp_round_rne #(
      .EXP_W  (EXP_W),
      .FRAC_W (FRAC_W)
   ) u_round (
      .i_mant      (r_mant[MW-2:0]),
      .i_exp       (r_exp),
      .o_exp_c     (w_rnd_exp),
      .o_frac_c    (w_rnd_frac)
`ifdef FP_NORM_FLAGS_EN
      ,
      .o_ovf_c     (w_rnd_ovf),
      .o_unf_c     (w_rnd_unf),
      .o_inexact_c (w_rnd_inx)
`endif
   );

   // Next-state and next-register values.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_sign  = r_sign;
      w_nxt_exp   = r_exp;
      w_nxt_mant  = r_mant;
      w_nxt_data  = r_out_data;
`ifdef FP_NORM_FLAGS_EN
      w_nxt_flags = r_flags;
`endif
      unique case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_nxt_sign = in_sign;
               w_nxt_exp  = w_in_exp;
               w_nxt_mant = in_mant;
`ifdef FP_NORM_FLAGS_EN
               w_nxt_flags = 3'b000;
`endif
               if (in_special) begin
                  w_nxt_data  = in_special_val;
                  w_nxt_state = DONE;
               end else begin
                  w_nxt_state = PRE;
               end
            end
         end
         PRE: begin
            if (r_mant == '0) begin
               w_nxt_data  = w_zero;
               w_nxt_state = DONE;
            end else if (r_mant[MW-1]) begin
               w_nxt_mant = w_shr_mant;
               w_nxt_exp  = w_exp_inc;
               if (w_exp_inc >= EXP_TOP) begin
                  w_nxt_data  = w_inf;
                  w_nxt_state = DONE;
`ifdef FP_NORM_FLAGS_EN
                  w_nxt_flags = 3'b100;
`endif
               end else begin
                  w_nxt_state = ROUND;
               end
            end else if (r_mant[MW-2] || (r_exp == EXP_ONE)) begin
               w_nxt_state = ROUND;
            end else begin
               w_nxt_state = NORM;
            end
         end
         NORM: begin
            w_nxt_mant = w_shl_mant;
            w_nxt_exp  = w_exp_dec;
            if (w_shl_mant[MW-2] || (w_exp_dec == EXP_ONE)) begin
               w_nxt_state = ROUND;
            end
         end
         ROUND: begin
            w_nxt_data  = {r_sign, w_rnd_exp, w_rnd_frac};
            w_nxt_state = DONE;
`ifdef FP_NORM_FLAGS_EN
            w_nxt_flags = {w_rnd_ovf, w_rnd_unf, w_rnd_inx};
`endif
         end
         DONE: begin
            if (out_ready) begin
               w_nxt_state = IDLE;
            end
         end
         default: begin
            w_nxt_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= IDLE;
         r_sign      <= 1'b0;
         r_exp       <= '0;
         r_mant      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
`ifdef FP_NORM_FLAGS_EN
         r_flags     <= 3'b000;
`endif
      end else begin
         r_state     <= w_nxt_state;
         r_sign      <= w_nxt_sign;
         r_exp       <= w_nxt_exp;
         r_mant      <= w_nxt_mant;
         r_out_data  <= w_nxt_data;
         r_out_valid <= (w_nxt_state == DONE);
         r_in_ready  <= (w_nxt_state == IDLE);
`ifdef FP_NORM_FLAGS_EN
         r_flags     <= w_nxt_flags;
`endif
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
`ifdef FP_NORM_FLAGS_EN
   assign out_flags = r_flags;
`endif

endmodule

// File: tb/tb_fp_norm_round.sv
// Randomised bench for fp_norm_round against an arithmetic RNE reference model.
module tb_fp_norm_round;
   import fp_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [27:0] in_mant;
   logic        in_special;
   logic [31:0] in_special_val;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
`ifdef FP_NORM_FLAGS_EN
   logic [2:0]  out_flags;
`endif

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   fp_norm_round #(.EXP_W(8), .FRAC_W(23)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_sign        (in_sign),
      .in_exp         (in_exp),
      .in_mant        (in_mant),
      .in_special     (in_special),
      .in_special_val (in_special_val),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data)
`ifdef FP_NORM_FLAGS_EN
      ,
      .out_flags      (out_flags)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
      end
   endtask

   // Reference: value-level normalise (shift count from leading one, clamped by
   // the exponent floor) followed by round-half-even on the discarded remainder.
   function automatic void ref_model(input logic s, input logic [7:0] e_in, input logic [27:0] m_in,
                                     output logic [31:0] d, output logic [2:0] f, output int lat);
      int              e, sh, p, nb, expf;
      longint unsigned mm, keep, rem, half;
      logic            up, inx;
      fp32_t           r;
      r.sign = s;
      r.exp  = '0;
      r.frac = '0;
      f      = 3'b000;
      e      = (e_in == 8'd0) ? 1 : int'(e_in);
      mm     = 64'(m_in);
      if (mm == 0) begin
         lat = 2;
         d   = r;
         return;
      end
      if (mm[27]) begin
         e = e + 1;
         if (e >= int'(EXP_MAX)) begin
            r.exp = '1;
            f     = 3'b100;
            lat   = 2;
            d     = r;
            return;
         end
         nb  = 4;
         lat = 3;
      end else begin
         p = 0;
         for (int i = 0; i < 27; i++) if (mm[i]) p = i;
         sh = 26 - p;
         if (sh > e - 1) sh = e - 1;
         mm  = mm << sh;
         e   = e - sh;
         nb  = 3;
         lat = 3 + sh;
      end
      keep = mm >> nb;
      rem  = mm & ((64'd1 << nb) - 64'd1);
      half = 64'd1 << (nb - 1);
      up   = (rem > half) || ((rem == half) && keep[0]);
      keep = keep + 64'(up);
      if (keep >= 64'h100_0000) begin
         keep = keep >> 1;
         e    = e + 1;
      end
      expf = (keep >= 64'h80_0000) ? e : 0;
      inx  = (rem != 0);
      if (expf >= int'(EXP_MAX)) begin
         r.exp = '1;
         f     = {1'b1, 1'b0, inx};
      end else begin
         r.exp  = 8'(expf);
         r.frac = 23'(keep);
         f      = {1'b0, (expf == 0) && inx, inx};
      end
      d = r;
   endfunction

   task automatic run_txn(input string tag, input logic s, input logic [7:0] e, input logic [27:0] m,
                          input logic sp, input logic [31:0] spv, input logic [31:0] want_d,
                          input logic [2:0] want_f, input int want_lat, input int hold);
      int cnt;
      cnt = 0;
      while (!in_ready && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      check({tag, ":idle_ready"}, 64'(in_ready), 64'd1);
      in_sign        = s;
      in_exp         = e;
      in_mant        = m;
      in_special     = sp;
      in_special_val = spv;
      in_valid       = 1'b1;
      @(posedge clk); #1;
      // Junk presented while busy must be ignored.
      in_sign        = 1'($urandom);
      in_exp         = 8'($urandom);
      in_mant        = 28'($urandom);
      in_special     = 1'($urandom);
      in_special_val = 32'($urandom);
      cnt = 1;
      while (!out_valid && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      in_valid = 1'b0;
      check({tag, ":latency"}, 64'(cnt), 64'(want_lat));
      check({tag, ":data"}, 64'(out_data), 64'(want_d));
`ifdef FP_NORM_FLAGS_EN
      check({tag, ":flags"}, 64'(out_flags), 64'(want_f));
`endif
      check({tag, ":busy_ready"}, 64'(in_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, ":hold_data"}, 64'(out_data), 64'(want_d));
         check({tag, ":hold_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ":drain_valid"}, 64'(out_valid), 64'd0);
      check({tag, ":drain_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [31:0] wd;
      logic [2:0]  wf;
      int          wl;
      rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_sign = 1'b0; in_exp = '0; in_mant = '0; in_special = 1'b0; in_special_val = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst:in_ready", 64'(in_ready), 64'd1);
      check("rst:out_valid", 64'(out_valid), 64'd0);
      check("rst:out_data", 64'(out_data), 64'd0);
`ifdef FP_NORM_FLAGS_EN
      check("rst:flags", 64'(out_flags), 64'd0);
`endif
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;

      run_txn("norm", 1'b0, 8'h80, {2'b01, 23'h07AE14, 3'b000}, 1'b0, 32'd0, 32'h4007_AE14, 3'b000, 3, 0);
      run_txn("carry", 1'b0, 8'(BIAS), 28'h800_0000, 1'b0, 32'd0, 32'h4000_0000, 3'b000, 3, 0);
      run_txn("carry_ovf", 1'b0, 8'hFE, 28'h800_0000, 1'b0, 32'd0, 32'h7F80_0000, 3'b100, 2, 0);
      run_txn("lshift3", 1'b0, 8'h82, 28'h080_0000, 1'b0, 32'd0, 32'h3F80_0000, 3'b000, 6, 0);
      run_txn("rnd_co", 1'b0, 8'h7F, {2'b01, 23'h7FFFFF, 3'b100}, 1'b0, 32'd0, 32'h4000_0000, 3'b001, 3, 1);
      run_txn("rnd_ovf", 1'b0, 8'hFE, {2'b01, 23'h7FFFFF, 3'b100}, 1'b0, 32'd0, 32'h7F80_0000, 3'b101, 3, 0);
      run_txn("zero_bp", 1'b1, 8'h55, 28'h0, 1'b0, 32'd0, 32'h8000_0000, 3'b000, 2, 5);
      run_txn("special", 1'b0, 8'h00, 28'h0, 1'b1, QNAN, QNAN, 3'b000, 1, 2);
      run_txn("subn", 1'b0, 8'h01, 28'h200_0000, 1'b0, 32'd0, 32'h0040_0000, 3'b000, 3, 0);
      run_txn("subn_up", 1'b0, 8'h01, {2'b00, 23'h7FFFFF, 3'b110}, 1'b0, 32'd0, 32'h0080_0000, 3'b001, 3, 0);
      run_txn("clamp", 1'b0, 8'h03, 28'h000_0400, 1'b0, 32'd0, 32'h0000_0200, 3'b000, 5, 0);

      // Reset in the middle of a long left-normalise sequence.
      in_sign = 1'b0; in_exp = 8'h90; in_mant = 28'h8; in_special = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      check("midrst:out_valid", 64'(out_valid), 64'd0);
      check("midrst:out_data", 64'(out_data), 64'd0);
      check("midrst:in_ready", 64'(in_ready), 64'd1);
      @(negedge clk) rstn = 1'b1;
      ref_model(1'b0, 8'h90, 28'h8, wd, wf, wl);
      run_txn("post_rst", 1'b0, 8'h90, 28'h8, 1'b0, 32'd0, wd, wf, wl, 0);

      for (int t = 0; t < 300; t++) begin
         int          cat, p;
         logic        s, sp;
         logic [7:0]  e;
         logic [27:0] m;
         logic [31:0] spv;
         cat = int'($urandom_range(0, 9));
         s   = 1'($urandom);
         sp  = 1'b0;
         spv = 32'($urandom);
         e   = 8'($urandom_range(1, 254));
         m   = 28'($urandom) & 28'h3FF_FFFF;
         case (cat)
            0: sp = 1'b1;
            1: m = '0;
            2: begin
               m = 28'($urandom) | 28'h800_0000;
               if ($urandom_range(0, 1) == 1) e = 8'($urandom_range(250, 254));
            end
            3, 4: m = m | 28'h400_0000;
            5: begin
               m = {2'b01, 23'h7FFFFF, 3'($urandom)};
               if ($urandom_range(0, 1) == 1) e = 8'($urandom_range(252, 254));
            end
            6, 7, 8: begin
               p = int'($urandom_range(0, 25));
               m = 28'd1 << p;
               m = m | (28'($urandom) & (m - 28'd1));
               if ($urandom_range(0, 1) == 1) e = 8'($urandom_range(1, 30));
            end
            default: begin
               e = 8'd0;
               m = 28'($urandom) & 28'h7FF_FFFF;
            end
         endcase
         if (sp) begin
            wd = spv;
            wf = 3'b000;
            wl = 1;
         end else begin
            ref_model(s, e, m, wd, wf, wl);
         end
         run_txn("rnd", s, e, m, sp, spv, wd, wf, wl, int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
